fft_chan_arb: RTL and testbench

Frame-granular round-robin scheduler sharing one streaming FFT core among NUM_CH per-antenna sample FIFOs. Holds the FFT core in reset after power-up, grants one channel per frame, drains exactly FRAME_LEN samples from the granted FIFO into the core with sop/eop framing, and tags each frame with its channel index. Sits between the per-channel ADC sample FIFOs and the FFT core input.

---
 rtl/fft_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 22 ++
 rtl/fft_chan_arb.sv | 106 ++++++++++
 tb/tb_fft_chan_arb.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: state encoding, default sizing and channel-index width helper for fft_chan_arb.
package fft_pkg;
  typedef enum logic [1:0] {S_INIT, S_IDLE, S_STREAM, S_GAP} state_t;
  localparam int NUM_CH_DEF = 4;
  localparam int FRAME_LEN_DEF = 128;
  localparam int RST_HOLD_DEF = 32;
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  localparam int CH_W = ch_w(NUM_CH_DEF);
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the lowest requester at or after last+1.
module rr_arbiter import fft_pkg::*; #(
  parameter int NUM_CH = NUM_CH_DEF,
  localparam int CW = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CW-1:0]     last,
  output logic [CW-1:0]     gnt,
  output logic              vld
);
  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt = '0;
    vld = 1'b0;
    for (int i = NUM_CH; i >= 1; i--) begin
      if (req[(int'(last) + i) % NUM_CH]) begin
        gnt = CW'((int'(last) + i) % NUM_CH);
        vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fft_chan_arb.sv
// fft_chan_arb: frame-granular round-robin feeder of one FFT core from NUM_CH sample FIFOs.
// Define FFT_ARB_STATS_EN to add per-channel frame counters and an underrun cycle counter.
module fft_chan_arb import fft_pkg::*; #(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DATA_W = 32,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int RST_HOLD = RST_HOLD_DEF,
  parameter int GAP = 2,
  localparam int CW = ch_w(NUM_CH)
) (
  input  logic                     clk_100m,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_avail,
  input  logic [NUM_CH-1:0]        ch_empty,
  output logic [NUM_CH-1:0]        ch_rdreq,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic                     fft_ready,
  output logic                     fft_rst_n,
  output logic                     fft_valid,
  output logic                     fft_sop,
  output logic                     fft_eop,
  output logic [DATA_W-1:0]        fft_data,
  output logic [CW-1:0]            fft_ch,
  output logic                     busy,
`ifdef FFT_ARB_STATS_EN
  output logic [NUM_CH*16-1:0]     stat_frames,
  output logic [15:0]              stat_underrun,
`endif
  output logic                     underrun
);
  localparam int NW = $clog2(FRAME_LEN) + 1;
  localparam int HW = $clog2(RST_HOLD + 1);
  localparam int GW = $clog2(GAP + 1);
  localparam logic [NW-1:0] FL = NW'(FRAME_LEN);
  state_t state, state_nx;
  logic [NW-1:0] rd_cnt;
  logic [HW-1:0] hold_cnt;
  logic [GW-1:0] gap_cnt;
  logic [CW-1:0] last_grant, gnt;
  logic gnt_vld, hold_done, rd, stall;
  logic [DATA_W-1:0] ch_word [NUM_CH];
  for (genvar g = 0; g < NUM_CH; g++) begin : g_word
    assign ch_word[g] = ch_data[g*DATA_W +: DATA_W];
  end
  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req(ch_avail),
    .last(last_grant),
    .gnt(gnt),
    .vld(gnt_vld)
  );
  assign hold_done = hold_cnt == HW'(RST_HOLD);
  assign rd = state == S_STREAM && fft_ready && !ch_empty[fft_ch] && rd_cnt < FL;
  assign stall = state == S_STREAM && fft_ready && ch_empty[fft_ch] && rd_cnt < FL;
  assign ch_rdreq = rd ? NUM_CH'(1) << fft_ch : '0;
  // FIFO q is already registered and arrives with fft_valid, so only a mux sits here.
  assign fft_data = fft_valid ? ch_word[fft_ch] : '0;
  always_ff @(posedge clk_100m or posedge rst)
    if (rst) state <= S_INIT;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      S_INIT:   state_nx = hold_done && fft_ready ? S_IDLE : S_INIT;
      S_IDLE:   state_nx = gnt_vld ? S_STREAM : S_IDLE;
      S_STREAM: state_nx = fft_eop ? S_GAP : S_STREAM;
      default:  state_nx = gap_cnt == GW'(GAP - 1) ? S_IDLE : S_GAP;
    endcase
  end
  always_ff @(posedge clk_100m or posedge rst)
    if (rst) begin
      hold_cnt   <= '0;
      fft_rst_n  <= 1'b0;
      gap_cnt    <= '0;
      rd_cnt     <= '0;
      fft_ch     <= '0;
      last_grant <= CW'(NUM_CH - 1);
      fft_valid  <= 1'b0;
      fft_sop    <= 1'b0;
      fft_eop    <= 1'b0;
      busy       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      hold_cnt   <= hold_done ? hold_cnt : hold_cnt + HW'(1);
      fft_rst_n  <= fft_rst_n | (hold_cnt == HW'(RST_HOLD - 1));
      gap_cnt    <= state == S_GAP ? gap_cnt + GW'(1) : '0;
      rd_cnt     <= state == S_IDLE ? '0 : rd_cnt + NW'(rd);
      fft_ch     <= state == S_IDLE && gnt_vld ? gnt : fft_ch;
      last_grant <= state == S_STREAM && fft_eop ? fft_ch : last_grant;
      fft_valid  <= rd;
      fft_sop    <= rd && rd_cnt == '0;
      fft_eop    <= rd && rd_cnt == FL - NW'(1);
      busy       <= state_nx == S_STREAM || state_nx == S_GAP;
      underrun   <= stall;
    end
`ifdef FFT_ARB_STATS_EN
  always_ff @(posedge clk_100m or posedge rst)
    if (rst) begin
      stat_frames   <= '0;
      stat_underrun <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (fft_eop && fft_ch == CW'(i)) stat_frames[i*16 +: 16] <= stat_frames[i*16 +: 16] + 16'd1;
      if (underrun && stat_underrun != 16'hFFFF) stat_underrun <= stat_underrun + 16'd1;
    end
`endif
endmodule

// File: tb/tb_fft_chan_arb.sv
// tb_fft_chan_arb: directed bench for fft_chan_arb with FIFO models and a frame monitor.
module tb_fft_chan_arb;
  logic clk_100m = 1'b0;
  logic rst = 1'b1;
  logic fft_ready = 1'b1;
  logic [3:0] ch_avail = 4'b1111;
  logic [3:0] ch_empty = 4'b0000;
  logic [3:0] ch_rdreq;
  logic [127:0] ch_data;
  logic fft_rst_n, fft_valid, fft_sop, fft_eop, busy, underrun;
  logic [31:0] fft_data;
  logic [1:0] fft_ch;
`ifdef FFT_ARB_STATS_EN
  logic [63:0] stat_frames;
  logic [15:0] stat_underrun;
`endif
  int errors = 0;
  int checks = 0;
  logic [31:0] ch_q [4] = '{default: '0};
  int rd_idx [4] = '{default: 0};
  int mon_idx [4] = '{default: 0};
  int cyc = 0, beats = 0, und = 0, data_bad = 0;
  int b0, u0, bad;
  logic [1:0] cur_ch = '0;
  logic chg = 1'b0;
  int sop_t[$], eop_t[$], fb[$], fc[$], fg[$];

  always #5 clk_100m = ~clk_100m;

  fft_chan_arb dut (
    .clk_100m(clk_100m),
    .rst(rst),
    .ch_avail(ch_avail),
    .ch_empty(ch_empty),
    .ch_rdreq(ch_rdreq),
    .ch_data(ch_data),
    .fft_ready(fft_ready),
    .fft_rst_n(fft_rst_n),
    .fft_valid(fft_valid),
    .fft_sop(fft_sop),
    .fft_eop(fft_eop),
    .fft_data(fft_data),
    .fft_ch(fft_ch),
    .busy(busy),
`ifdef FFT_ARB_STATS_EN
    .stat_frames(stat_frames),
    .stat_underrun(stat_underrun),
`endif
    .underrun(underrun)
  );

  always_comb
    for (int c = 0; c < 4; c++) ch_data[c*32 +: 32] = ch_q[c];

  // Normal-mode FIFOs: each word is {channel, sequence number}, valid one cycle after rdreq.
  always @(posedge clk_100m)
    for (int c = 0; c < 4; c++)
      if (ch_rdreq[c]) begin
        ch_q[c] <= {8'(c), 24'(rd_idx[c])};
        rd_idx[c] <= rd_idx[c] + 1;
      end

  always @(negedge clk_100m) begin
    cyc++;
    if (underrun) und++;
    if (fft_valid) begin
      if (fft_sop) begin
        beats = 0;
        cur_ch = fft_ch;
        chg = 1'b0;
        sop_t.push_back(cyc);
      end
      beats++;
      if (fft_ch != cur_ch) chg = 1'b1;
      if (fft_data !== {8'(fft_ch), 24'(mon_idx[fft_ch])}) data_bad++;
      mon_idx[fft_ch]++;
      if (fft_eop) begin
        fb.push_back(beats);
        fc.push_back(int'(cur_ch));
        fg.push_back(int'(chg));
        eop_t.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(negedge clk_100m);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_rdreq"}, 64'(ch_rdreq), 0);
    check({pfx, "_fft_rst_n"}, 64'(fft_rst_n), 0);
    check({pfx, "_valid"}, 64'(fft_valid), 0);
    check({pfx, "_sop_eop"}, 64'({fft_sop, fft_eop}), 0);
    check({pfx, "_data"}, 64'(fft_data), 0);
    check({pfx, "_ch"}, 64'(fft_ch), 0);
    check({pfx, "_busy"}, 64'(busy), 0);
    check({pfx, "_underrun"}, 64'(underrun), 0);
  endtask

  task automatic measure_hold(input string pfx);
    int n = 0;
    int q = 0;
    while (!fft_rst_n && n < 200) begin
      step();
      n++;
      if (ch_rdreq != 0 || busy) q++;
    end
    check({pfx, "_hold_len"}, 64'(n), 32);
    check({pfx, "_init_quiet"}, 64'(q), 0);
    step();
    check({pfx, "_idle_no_grant"}, 64'({busy, ch_rdreq}), 0);
    step();
    check({pfx, "_first_rdreq"}, 64'(ch_rdreq), 64'b0001);
    check({pfx, "_first_ch"}, 64'(fft_ch), 0);
    check({pfx, "_first_busy"}, 64'(busy), 1);
  endtask

  task automatic wait_frames(input string tag, input int nsop, input int nbeats, input int neop);
    int g = 0;
    while (!(sop_t.size() >= nsop && beats >= nbeats && fb.size() >= neop) && g < 3000) begin
      step();
      g++;
    end
    check({tag, "_timeout"}, 64'(g >= 3000), 0);
  endtask

  task automatic check_frame(input int i, input int ch);
    check($sformatf("frame%0d_present", i), 64'(fb.size() > i), 1);
    if (fb.size() > i) begin
      check($sformatf("frame%0d_ch", i), 64'(fc[i]), 64'(ch));
      check($sformatf("frame%0d_beats", i), 64'(fb[i]), 128);
      check($sformatf("frame%0d_ch_stable", i), 64'(fg[i]), 0);
    end
  endtask

  initial begin
    repeat (3) step();
    check_zero("reset");
    rst = 1'b0;
    measure_hold("boot");
    wait_frames("rr", 5, 0, 5);
    ch_avail = 4'b0000;
    check("rr_period", 64'(sop_t[1] - sop_t[0]), 132);
    check("rr_sop_to_eop", 64'(eop_t[0] - sop_t[0]), 127);
    for (int i = 0; i < 5; i++) check_frame(i, i % 4);
    repeat (6) step();
    check("idle_stay", 64'({busy, ch_rdreq}), 0);
    ch_avail = 4'b0100;
    wait_frames("ch2_mid", 6, 20, 5);
    ch_avail = 4'b0010;
    wait_frames("ch2_done", 6, 0, 6);
    check_frame(5, 2);
    wait_frames("ch1_start", 7, 0, 6);
    check("gap_eop_to_sop", 64'(sop_t[6] - eop_t[5]), 5);
    ch_avail = 4'b0000;
    wait_frames("ch1_mid", 7, 40, 6);
    @(posedge clk_100m);
    #1 fft_ready = 1'b0;
    b0 = beats;
    u0 = und;
    bad = 0;
    repeat (10) begin
      @(negedge clk_100m);
      #1;
      if (ch_rdreq != 0) bad++;
    end
    check("stall_extra_beat", 64'(beats - b0), 1);
    check("stall_no_rdreq", 64'(bad), 0);
    @(posedge clk_100m);
    #1 fft_ready = 1'b1;
    wait_frames("ch1_done", 7, 0, 7);
    check_frame(6, 1);
    check("stall_no_underrun", 64'(und - u0), 0);
    ch_avail = 4'b1000;
    wait_frames("ch3_mid", 8, 30, 7);
    ch_avail = 4'b0000;
    @(posedge clk_100m);
    #1 ch_empty = 4'b1000;
    u0 = und;
    b0 = beats;
    repeat (5) @(posedge clk_100m);
    #1 ch_empty = 4'b0000;
    check("empty_in_flight_beat", 64'(beats - b0), 1);
    wait_frames("ch3_done", 8, 0, 8);
    check_frame(7, 3);
    check("underrun_cycles", 64'(und - u0), 5);
    ch_avail = 4'b1111;
    wait_frames("ch0_mid", 9, 60, 8);
    check("rst_at_beat", 64'(beats), 60);
`ifdef FFT_ARB_STATS_EN
    check("stat_frames_pre", stat_frames, 64'h0002_0002_0002_0002);
    check("stat_underrun_pre", 64'(stat_underrun), 5);
`endif
    rst = 1'b1;
    #1;
    check_zero("mid_rst");
`ifdef FFT_ARB_STATS_EN
    check("stat_frames_rst", stat_frames, 0);
    check("stat_underrun_rst", 64'(stat_underrun), 0);
`endif
    repeat (3) step();
    rst = 1'b0;
    measure_hold("reboot");
    wait_frames("post_rst", 10, 0, 9);
    check_frame(8, 0);
    check("data_order", 64'(data_bad), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
